reset_sequencer: RTL

Multi-source, multi-stage reset controller for the board test system. It takes NUM_SOURCES asynchronous active-low reset requests plus a software request, synchronizes and glitch-filters each source, and drives NUM_STAGES active-low reset outputs. The outputs are asserted together and released in order, with a programmable hold time and inter-stage gap, for example PLL/clock logic, then fabric, then host interface. It sits at the top level in place of the single-output reset generator and records a sticky reset cause for firmware.

---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/reset_sequencer_if.sv | 29 ++
 rtl/reset_source_filter.sv | 53 +++++
 rtl/reset_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state type and cause-bit indices.
package reset_seq_pkg;

  // Sequencer phases: all outputs held, hold timer, staged release, idle
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_t;

  // Cause register layout: source bits first, then software, then power-on
  function automatic int cause_sw_idx(input int num_sources);
    return num_sources;
  endfunction

  function automatic int cause_por_idx(input int num_sources);
    return num_sources + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle of the reset sequencer. The master side is the
// board logic / firmware that raises requests and reads status, the slave
// side is the sequencer itself.
interface reset_sequencer_if #(
  parameter int NUM_SOURCES = 4,
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_WIDTH  = 16,
  parameter int GAP_WIDTH   = 8
);
  logic [NUM_SOURCES-1:0] src_resetn;
  logic [NUM_SOURCES-1:0] src_mask;
  logic                   sw_reset_req;
  logic [HOLD_WIDTH-1:0]  hold_cycles;
  logic [GAP_WIDTH-1:0]   stage_gap;
  logic                   cause_clr;
  logic [NUM_STAGES-1:0]  stage_resetn;
  logic                   busy;
  logic [NUM_SOURCES+1:0] cause;

  modport master (
    output src_resetn, src_mask, sw_reset_req, hold_cycles, stage_gap, cause_clr,
    input  stage_resetn, busy, cause
  );

  modport slave (
    input  src_resetn, src_mask, sw_reset_req, hold_cycles, stage_gap, cause_clr,
    output stage_resetn, busy, cause
  );
endinterface

// File: rtl/reset_source_filter.sv
// One reset source: 2-FF synchronizer followed by a saturating low-run
// counter. filt goes high once the synchronized request has been low for
// FILTER_CYCLES consecutive cycles and drops as soon as it is seen high.
module reset_source_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic src_resetn,
  output logic filt
);

  localparam int CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Bring the asynchronous request into the clk domain; idle level is high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= src_resetn;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive low cycles, saturating at the threshold
  always_comb begin
    count_next = count_reg;
    if (sync2_reg) begin
      count_next = '0;
    end else if (count_reg != CNT_MAX) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Register the low-run count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign filt = (count_reg == CNT_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// Multi-source reset controller: filters each source, asserts all stage
// resets together on any trigger, then releases them in order after a
// programmable hold and inter-stage gap. Keeps a sticky cause register.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_SOURCES   = 4,
  parameter int NUM_STAGES    = 3,
  parameter int FILTER_CYCLES = 4,
  parameter int HOLD_WIDTH    = 16,
  parameter int GAP_WIDTH     = 8
) (
  input  logic               clk,
  input  logic               resetn,
  reset_sequencer_if.slave   bus
);

  localparam int CAUSE_W   = NUM_SOURCES + 2;
  localparam int CAUSE_SW  = cause_sw_idx(NUM_SOURCES);
  localparam int CAUSE_POR = cause_por_idx(NUM_SOURCES);

  localparam logic [CAUSE_W-1:0]    CAUSE_RST   = {1'b1, {(NUM_SOURCES+1){1'b0}}};
  localparam logic [NUM_STAGES-1:0] STAGE_FIRST = NUM_STAGES'(1);

  logic [NUM_SOURCES-1:0] filt;
  logic [NUM_SOURCES-1:0] src_hits;
  logic                   src_active;
  logic                   trigger;

  seq_state_t             state_reg, state_next;
  logic [HOLD_WIDTH-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [HOLD_WIDTH-1:0]  hold_lat_reg, hold_lat_next;
  logic [GAP_WIDTH-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [GAP_WIDTH-1:0]   gap_lat_reg, gap_lat_next;
  logic [NUM_STAGES-1:0]  stage_reg, stage_next;
  logic [NUM_STAGES-1:0]  stage_shift;
  logic                   busy_reg, busy_next;
  logic [CAUSE_W-1:0]     cause_reg, cause_next;
  logic [CAUSE_W-1:0]     cause_set;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      reset_source_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filter (
        .clk        (clk),
        .resetn     (resetn),
        .src_resetn (bus.src_resetn[gi]),
        .filt       (filt[gi])
      );
    end
  endgenerate

  assign src_hits   = filt & ~bus.src_mask;
  assign src_active = |src_hits;
  assign trigger    = src_active | bus.sw_reset_req;

  // Cause bits to be set this cycle; a set beats a simultaneous clear
  always_comb begin
    cause_set = '0;
    if (trigger) begin
      cause_set[NUM_SOURCES-1:0] = src_hits;
      cause_set[CAUSE_SW]        = bus.sw_reset_req;
    end
    cause_next = (bus.cause_clr ? '0 : cause_reg) | cause_set;
  end

  // Sequencer next state: trigger overrides everything, else walk the phases
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    hold_lat_next = hold_lat_reg;
    gap_cnt_next  = gap_cnt_reg;
    gap_lat_next  = gap_lat_reg;
    stage_next    = stage_reg;
    busy_next     = busy_reg;
    // thermometer step: the lowest still-asserted stage gets released
    stage_shift   = (stage_reg << 1) | STAGE_FIRST;

    if (trigger) begin
      state_next = ST_ASSERT;
      stage_next = '0;
      busy_next  = 1'b1;
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          // no trigger means no active source, so leave on this edge
          state_next    = ST_HOLD;
          hold_lat_next = bus.hold_cycles;
          gap_lat_next  = bus.stage_gap;
          hold_cnt_next = '0;
        end
        ST_HOLD: begin
          if (hold_cnt_reg == hold_lat_reg) begin
            stage_next   = STAGE_FIRST;
            gap_cnt_next = '0;
            if (NUM_STAGES == 1) begin
              state_next = ST_RUN;
              busy_next  = 1'b0;
            end else begin
              state_next = ST_RELEASE;
            end
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_cnt_reg == gap_lat_reg) begin
            stage_next   = stage_shift;
            gap_cnt_next = '0;
            if (&stage_shift) begin
              state_next = ST_RUN;
              busy_next  = 1'b0;
            end
          end else begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          state_next = ST_RUN;
        end
        default: begin
          state_next = ST_ASSERT;
          stage_next = '0;
          busy_next  = 1'b1;
        end
      endcase
    end
  end

  // Sequencer registers; power-on behaves like a maximal hold/gap sequence
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_HOLD;
      hold_cnt_reg <= '0;
      hold_lat_reg <= '1;
      gap_cnt_reg  <= '0;
      gap_lat_reg  <= '1;
      stage_reg    <= '0;
      busy_reg     <= 1'b1;
      cause_reg    <= CAUSE_RST;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      hold_lat_reg <= hold_lat_next;
      gap_cnt_reg  <= gap_cnt_next;
      gap_lat_reg  <= gap_lat_next;
      stage_reg    <= stage_next;
      busy_reg     <= busy_next;
      cause_reg    <= cause_next;
    end
  end

  assign bus.stage_resetn = stage_reg;
  assign bus.busy         = busy_reg;
  assign bus.cause        = cause_reg;

endmodule
